// File: rtl/lcd_text_builder.sv
// Character-LCD frame builder: latches a value, converts it to BCD by double-dabble,
// then streams a 32-character "DEC:/HEX:" frame. Optional macro LEAD_ZERO_BLANK_EN.
module lcd_text_builder #(
    parameter int VAL_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [4:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [VAL_W-1:0]   r_value;
    logic [VAL_W-1:0]   r_shift;
    logic [23:0]        r_bcd;
    logic [4:0]         r_iter;
    logic               r_busy;
    logic               r_wr_valid;
    logic [4:0]         r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_done;

    logic [23:0]        w_bcd_adj;
    logic [19:0]        w_hex;
    logic [4:0]         w_next_addr;
    logic [7:0]         w_first_char;
    logic [7:0]         w_next_char;

    function automatic logic [23:0] dabble_adjust(input logic [23:0] bcd);
        logic [23:0] res;
        res = 24'd0;
        for (int d = 0; d < 6; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] nib, input logic blank);
        logic [7:0] ch;
        if (blank) begin
            ch = 8'h20;
        end else begin
            ch = {4'h3, nib};
        end
        return ch;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = {4'h3, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

    function automatic logic [7:0] frame_char(input logic [4:0] addr,
                                              input logic [23:0] bcd,
                                              input logic [19:0] hex);
        logic [7:0] ch;
        logic [4:0] blank;
`ifdef LEAD_ZERO_BLANK_EN
        // A digit blanks only when it and every more significant digit are zero.
        blank[0] = (bcd[23:20] == 4'd0);
        blank[1] = blank[0] && (bcd[19:16] == 4'd0);
        blank[2] = blank[1] && (bcd[15:12] == 4'd0);
        blank[3] = blank[2] && (bcd[11:8] == 4'd0);
        blank[4] = blank[3] && (bcd[7:4] == 4'd0);
`else
        blank = 5'd0;
`endif
        case (addr)
            5'd0:    ch = 8'h44;
            5'd1:    ch = 8'h45;
            5'd2:    ch = 8'h43;
            5'd3:    ch = 8'h3A;
            5'd5:    ch = dec_char(bcd[23:20], blank[0]);
            5'd6:    ch = dec_char(bcd[19:16], blank[1]);
            5'd7:    ch = dec_char(bcd[15:12], blank[2]);
            5'd8:    ch = dec_char(bcd[11:8], blank[3]);
            5'd9:    ch = dec_char(bcd[7:4], blank[4]);
            5'd10:   ch = dec_char(bcd[3:0], 1'b0);
            5'd16:   ch = 8'h48;
            5'd17:   ch = 8'h45;
            5'd18:   ch = 8'h58;
            5'd19:   ch = 8'h3A;
            5'd21:   ch = hex_char(hex[19:16]);
            5'd22:   ch = hex_char(hex[15:12]);
            5'd23:   ch = hex_char(hex[11:8]);
            5'd24:   ch = hex_char(hex[7:4]);
            5'd25:   ch = hex_char(hex[3:0]);
            default: ch = 8'h20;
        endcase
        return ch;
    endfunction

    assign w_bcd_adj    = dabble_adjust(r_bcd);
    assign w_hex        = 20'(r_value);
    assign w_next_addr  = r_wr_addr + 5'd1;
    assign w_first_char = frame_char(5'd0, r_bcd, w_hex);
    assign w_next_char  = frame_char(w_next_addr, r_bcd, w_hex);

    // Frame sequencer: conversion, character streaming and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_value    <= '0;
            r_shift    <= '0;
            r_bcd      <= 24'd0;
            r_iter     <= 5'd0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_value <= value;
                        r_shift <= value;
                        r_bcd   <= 24'd0;
                        r_iter  <= 5'(VAL_W);
                        r_busy  <= 1'b1;
                        r_state <= ST_CONVERT;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd   <= {w_bcd_adj[22:0], r_shift[VAL_W-1]};
                    r_shift <= r_shift << 1;
                    r_iter  <= r_iter - 5'd1;
                    if (r_iter == 5'd1) begin
                        r_state <= ST_EMIT;
                    end else begin
                        r_state <= ST_CONVERT;
                    end
                end
                ST_EMIT: begin
                    // First EMIT cycle only loads character 0; the BCD result is final by then.
                    if (!r_wr_valid) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= 5'd0;
                        r_wr_data  <= w_first_char;
                    end else if (wr_ready) begin
                        if (r_wr_addr == 5'd31) begin
                            r_wr_valid <= 1'b0;
                            r_wr_addr  <= 5'd0;
                            r_wr_data  <= 8'd0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_wr_addr  <= w_next_addr;
                            r_wr_data  <= w_next_char;
                        end
                    end else begin
                        r_wr_addr  <= r_wr_addr;
                        r_wr_data  <= r_wr_data;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_wr_valid <= 1'b0;
                    r_wr_addr  <= 5'd0;
                    r_wr_data  <= 8'd0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign done     = r_done;

endmodule

// File: tb/tb_lcd_text_builder.sv
// Directed self-checking bench for lcd_text_builder (VAL_W = 18).
module tb_lcd_text_builder;

    localparam int VAL_W = 18;

    logic             clk;
    logic             rst;
    logic             start;
    logic [VAL_W-1:0] value;
    logic             busy;
    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             done;

    int vectors;
    int miscompares;

    lcd_text_builder #(.VAL_W(VAL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge just after the accepting edge.
    task automatic start_frame(input logic [VAL_W-1:0] v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = ~v;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("valid_after_start", {31'd0, wr_valid}, 32'd0);
    endtask

    task automatic check_frame(input string d6, input string h5, input int stall, input int cyc0);
        string      l1;
        string      l2;
        int         cyc;
        int         idx;
        int         stalls;
        int         first_valid;
        logic       held;
        logic [4:0] ha;
        logic [7:0] hd;
        logic [7:0] ec;
        l1 = {"DEC: ", d6, "     "};
        l2 = {"HEX: ", h5, "      "};
        cyc = cyc0;
        idx = 0;
        stalls = 0;
        first_valid = -1;
        held = 1'b0;
        ha = 5'd0;
        hd = 8'd0;
        while (idx < 32 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall != 0 && stalls < 20 && (cyc % 5) < 2 && wr_valid) begin
                wr_ready = 1'b0;
                stalls++;
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (held) begin
                    chk("stall_addr", {27'd0, wr_addr}, {27'd0, ha});
                    chk("stall_data", {24'd0, wr_data}, {24'd0, hd});
                end
                ec = (idx < 16) ? l1[idx] : l2[idx-16];
                chk("addr", {27'd0, wr_addr}, idx);
                chk("data", {24'd0, wr_data}, {24'd0, ec});
                if (wr_ready) begin
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    ha = wr_addr;
                    hd = wr_data;
                end
            end else begin
                chk("busy_pre", {31'd0, busy}, 32'd1);
                chk("idle_bus", {19'd0, wr_addr, wr_data}, 32'd0);
            end
        end
        wr_ready = 1'b1;
        chk("transfers", idx, 32);
        if (stall == 0) chk("first_valid_cyc", first_valid, VAL_W + 1);
        @(negedge clk);
        cyc++;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, wr_valid}, 32'd0);
        chk("done_bus", {19'd0, wr_addr, wr_data}, 32'd0);
        if (stall == 0) chk("done_cyc", cyc, VAL_W + 33);
        @(negedge clk);
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("busy_clear", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        string d_0, d_262143, d_1234, d_99999, d_65535, d_42;
`ifdef LEAD_ZERO_BLANK_EN
        d_0      = "     0";
        d_262143 = "262143";
        d_1234   = "  1234";
        d_99999  = " 99999";
        d_65535  = " 65535";
        d_42     = "    42";
`else
        d_0      = "000000";
        d_262143 = "262143";
        d_1234   = "001234";
        d_99999  = "099999";
        d_65535  = "065535";
        d_42     = "000042";
`endif
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        value = '0;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, wr_valid}, 32'd0);
        chk("reset_bus", {19'd0, wr_addr, wr_data}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Zero value, then the largest 18-bit value
        start_frame(18'd0);
        check_frame(d_0, "00000", 0, 0);
        start_frame(18'h3FFFF);
        check_frame(d_262143, "3FFFF", 0, 0);

        // Back-pressure with consecutive stalls
        start_frame(18'd1234);
        check_frame(d_1234, "004D2", 1, 0);

        // Second start while busy is ignored; a start after done is served
        start_frame(18'd99999);
        repeat (7) @(negedge clk);
        value = 18'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_frame(d_99999, "1869F", 0, 8);
        start_frame(18'd100000);
        check_frame("100000", "186A0", 0, 0);

        // Reset in the middle of EMIT
        start_frame(18'd5);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wr_valid && wr_addr == 5'd10) break;
        end
        chk("reach_addr10", {26'd0, wr_valid, wr_addr}, {26'd0, 1'b1, 5'd10});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", {31'd0, wr_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        start_frame(18'd65535);
        check_frame(d_65535, "0FFFF", 0, 0);

        start_frame(18'd42);
        check_frame(d_42, "0002A", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_text_builder.md
Name: lcd_text_builder

Overview:
Upstream feeder for the character-LCD controller. On a start pulse it latches a binary value (e.g. the slide switches) and converts it to decimal BCD with an iterative shift-add-3 (double-dabble) loop. It then streams a 32-character ASCII frame, 16 characters per line, over a valid/ready write port into the LCD controller's display buffer. It signals frame completion with a one-cycle pulse.

Parameters:
VAL_W, 18, width of the input value; legal range 1..19, so the value always fits in 6 decimal digits and 5 hex digits.

Ports:
clk  in  1  system clock, 50 MHz.
rst  in  1  reset; synchronous, active-high.
start  in  1  frame request; sampled only while busy=0.
value  in  VAL_W  binary value to display; latched when start is accepted.
busy  out  1  high from the cycle after start is accepted until done.
wr_valid  out  1  character write request.
wr_ready  in  1  buffer accepts the write.
wr_addr  out  5  character position; 0..15 is line 1, 16..31 is line 2.
wr_data  out  8  ASCII character.
done  out  1  one-cycle pulse after the addr-31 transfer.

Behaviour:
- Reset: all outputs 0, state IDLE, value latch and BCD register cleared. Reset takes effect on the next edge from any state, including mid-CONVERT or mid-EMIT. No partial frame is resumed.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch value, clear BCD, set the iteration counter to VAL_W, and go to CONVERT.
  - CONVERT: one double-dabble iteration per cycle over 6 BCD digits. Each digit ≥5 gets +3, then the register shifts left 1, taking the value MSB. After VAL_W iterations, go to EMIT with addr=0.
  - EMIT: wr_valid=1, with wr_addr and wr_data driven from the current index. A transfer occurs at an edge where wr_valid&wr_ready=1.
    - After a transfer with addr<31: index+1, and the next character is presented the following cycle. wr_valid stays high, giving back-to-back transfers when wr_ready is held high.
    - While wr_ready=0: addr and data are held stable.
    - After the addr-31 transfer: go to DONE.
  - DONE: done=1 and wr_valid=0 for one cycle, then IDLE.
- Latency: start sampled at edge N → busy=1 after edge N. The first wr_valid=1 appears after edge N+VAL_W+1. With wr_ready tied high, done pulses after edge N+VAL_W+33.
- start while busy=1 is ignored, not queued. Changes to value after acceptance have no effect on the frame.
- Frame layout:
  - Line 1: addr 0-3 "DEC:", 4 space, 5-10 six decimal digits MSD first, 11-15 spaces.
  - Line 2: addr 16-19 "HEX:", 20 space, 21-25 five uppercase hex digits of value zero-extended to 20 bits, leading zeros always shown, 26-31 spaces.
- ASCII mapping: digits 0x30+d; hex A-F are 0x41-0x46; space is 0x20.
- wr_data and wr_addr are 0 whenever wr_valid=0.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: decimal leading zeros (addr 5-9) are output as space 0x20. Addr 10, the least significant digit, is always a digit, so value 0 shows "     0".
- Undefined: all six decimal digits are shown, including leading zeros. The hex field is unaffected in both cases.

Test Plan:
1. Macro defined, value=0, wr_ready=1 → line 1 "DEC:      0     ", line 2 "HEX: 00000      ". Exactly 32 transfers at addr 0..31; done pulses once after edge N+51 (VAL_W=18).
2. value=262143 (0x3FFFF) → "DEC: 262143     " and "HEX: 3FFFF      ". busy high for exactly the expected cycle span.
3. value=1234, wr_ready randomly toggled (20 stall cycles including consecutive stalls) → "DEC:   1234     " and "HEX: 004D2      ". addr and data stable during stalls; no duplicate or skipped addresses.
4. start pulsed at cycles 5 and 12 with different values → only the first value is displayed. A new start accepted after done produces a second complete frame.
5. rst asserted during EMIT at addr 10 → after the next edge wr_valid=0, busy=0, done=0. A subsequent start produces a full frame starting at addr 0.
6. Macro undefined, value=42 → "DEC: 000042     ". Hex line "HEX: 0002A      ".
